// File: rtl/akuma_move_ctrl.sv
// Movement/attack controller for the Akuma sprite: stand/punch/jump FSM with ballistic jump and clamped walking.
// Optional build macro AKUMA_AIR_PUNCH_EN enables punching while airborne.
module akuma_move_ctrl #(
   parameter int X_INIT       = 100,
   parameter int GROUND_Y     = 300,
   parameter int X_MIN        = 0,
   parameter int X_MAX        = 560,
   parameter int STEP         = 2,
   parameter int PUNCH_FRAMES = 12,
   parameter int JUMP_V       = 12
) (
   input  logic       vga_clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_jump,
   input  logic       btn_punch,
   output logic [9:0] AkumaX,
   output logic [9:0] AkumaY,
   output logic [2:0] sprite,
   output logic       attack_active
);

   // state    | meaning
   // ST_STAND | on the ground, may walk, jump or start a punch
   // ST_PUNCH | ground punch, frozen in place for PUNCH_FRAMES ticks
   // ST_JUMP  | airborne, Y follows vy with +1 gravity per tick
   typedef enum logic [1:0] {ST_STAND, ST_PUNCH, ST_JUMP} state_t;

   localparam logic signed [11:0] X_MIN_S  = 12'(X_MIN);
   localparam logic signed [11:0] X_MAX_S  = 12'(X_MAX);
   localparam logic signed [11:0] STEP_S   = 12'(STEP);
   localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
   localparam logic signed [10:0] JV_Y     = 11'(JUMP_V);
   localparam logic signed [7:0]  JV_S     = 8'(JUMP_V);
   localparam logic [5:0]         PF_M1    = 6'(PUNCH_FRAMES - 1);
   localparam logic [2:0]         SPR_STAND = 3'd0;
   localparam logic [2:0]         SPR_PUNCH = 3'd1;
   localparam logic [2:0]         SPR_JUMP  = 3'd2;

   state_t            state_q, state_d;
   logic [9:0]        x_q, x_d;
   logic [9:0]        y_q, y_d;
   logic signed [7:0] vy_q, vy_d;
   logic [5:0]        cnt_q, cnt_d;
   logic              punch_prev_q, punch_prev_d;
   logic              air_q, air_d;
   logic [2:0]        sprite_q, sprite_d;
   logic              atk_q, atk_d;

   logic               punch_edge;
   logic signed [11:0] x_ext, x_step;
   logic [9:0]         x_moved;
   logic signed [10:0] y_ext, y_sum, y_launch;

   // Horizontal step is computed wide and signed so clamping never sees a wrapped value.
   always_comb begin
      x_ext  = $signed({2'b00, x_q});
      x_step = x_ext;
      if (btn_left && !btn_right) begin
         x_step = x_ext - STEP_S;
      end else if (btn_right && !btn_left) begin
         x_step = x_ext + STEP_S;
      end
      if (x_step < X_MIN_S) begin
         x_moved = X_MIN_S[9:0];
      end else if (x_step > X_MAX_S) begin
         x_moved = X_MAX_S[9:0];
      end else begin
         x_moved = x_step[9:0];
      end
   end

   assign punch_edge = btn_punch && !punch_prev_q;
   assign y_ext      = $signed({1'b0, y_q});
   assign y_sum      = y_ext + $signed({{3{vy_q[7]}}, vy_q});
   assign y_launch   = y_ext - JV_Y;

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      vy_d         = vy_q;
      cnt_d        = cnt_q;
      punch_prev_d = punch_prev_q;
      air_d        = air_q;

      if (frame_tick) begin
         punch_prev_d = btn_punch;
         unique case (state_q)
            ST_STAND: begin
               if (btn_jump) begin
                  state_d = ST_JUMP;
                  y_d     = y_launch[9:0];
                  vy_d    = -JV_S + 8'sd1;
               end else if (punch_edge) begin
                  state_d = ST_PUNCH;
                  cnt_d   = PF_M1;
               end else begin
                  x_d = x_moved;
               end
            end
            ST_PUNCH: begin
               if (cnt_q == 6'd0) begin
                  state_d = ST_STAND;
               end else begin
                  cnt_d = cnt_q - 6'd1;
               end
            end
            ST_JUMP: begin
               x_d = x_moved;
`ifdef AKUMA_AIR_PUNCH_EN
               if (air_q) begin
                  if (cnt_q == 6'd0) begin
                     air_d = 1'b0;
                  end else begin
                     cnt_d = cnt_q - 6'd1;
                  end
               end else if (punch_edge) begin
                  air_d = 1'b1;
                  cnt_d = PF_M1;
               end
`endif
               // Landing overrides any air-punch bookkeeping above.
               if (y_sum >= GROUND_S) begin
                  state_d = ST_STAND;
                  y_d     = GROUND_S[9:0];
                  vy_d    = 8'sd0;
                  air_d   = 1'b0;
                  cnt_d   = 6'd0;
               end else begin
                  y_d  = y_sum[9:0];
                  vy_d = vy_q + 8'sd1;
               end
            end
            default: begin
               state_d = ST_STAND;
            end
         endcase
      end
   end

   always_comb begin
      sprite_d = SPR_STAND;
      unique case (state_d)
         ST_PUNCH: sprite_d = SPR_PUNCH;
         ST_JUMP:  sprite_d = air_d ? SPR_PUNCH : SPR_JUMP;
         default:  sprite_d = SPR_STAND;
      endcase
      atk_d = (sprite_d == SPR_PUNCH);
   end

   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         state_q      <= ST_STAND;
         x_q          <= 10'(X_INIT);
         y_q          <= 10'(GROUND_Y);
         vy_q         <= 8'sd0;
         cnt_q        <= 6'd0;
         punch_prev_q <= 1'b0;
         air_q        <= 1'b0;
         sprite_q     <= SPR_STAND;
         atk_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         vy_q         <= vy_d;
         cnt_q        <= cnt_d;
         punch_prev_q <= punch_prev_d;
         air_q        <= air_d;
         sprite_q     <= sprite_d;
         atk_q        <= atk_d;
      end
   end

   assign AkumaX        = x_q;
   assign AkumaY        = y_q;
   assign sprite        = sprite_q;
   assign attack_active = atk_q;

endmodule

// File: tb/tb_akuma_move_ctrl.sv
// Scoreboard bench for akuma_move_ctrl: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_akuma_move_ctrl;

   logic       vga_clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0, btn_punch = 1'b0;
   logic [9:0] AkumaX, AkumaY;
   logic [2:0] sprite;
   logic       attack_active;
   logic       chk = 1'b0;
   logic       take;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] spr;
      logic       atk;
      string      nm;
   } exp_t;
   exp_t sb[$];

   // Y after each jump tick 1..25 for JUMP_V=12, GROUND_Y=300.
   int jy[25] = '{288, 277, 267, 258, 250, 243, 237, 232, 228, 225, 223, 222, 222,
                  223, 225, 228, 232, 237, 243, 250, 258, 267, 277, 288, 300};
   int lx[5]  = '{2, 0, 0, 0, 0};

`ifdef AKUMA_AIR_PUNCH_EN
   localparam int AIR_SPR = 1;
`else
   localparam int AIR_SPR = 2;
`endif

   akuma_move_ctrl dut (
      .vga_clk       (vga_clk),
      .Reset         (Reset),
      .frame_tick    (frame_tick),
      .btn_left      (btn_left),
      .btn_right     (btn_right),
      .btn_jump      (btn_jump),
      .btn_punch     (btn_punch),
      .AkumaX        (AkumaX),
      .AkumaY        (AkumaY),
      .sprite        (sprite),
      .attack_active (attack_active)
   );

   always #5 vga_clk = ~vga_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got %0d/%0d checks", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int tk, l, r, j, p, rst, ck, ex, ey, es, input string nm);
      exp_t e;
      @(negedge vga_clk);
      frame_tick = (tk != 0);
      btn_left   = (l != 0);
      btn_right  = (r != 0);
      btn_jump   = (j != 0);
      btn_punch  = (p != 0);
      Reset      = (rst != 0);
      chk        = (ck != 0);
      if (ck != 0) begin
         e.x   = 10'(ex);
         e.y   = 10'(ey);
         e.spr = 3'(es);
         e.atk = (es == 1);
         e.nm  = nm;
         sb.push_back(e);
      end
   endtask

   task automatic tick(input int l, r, j, p, ex, ey, es, input string nm);
      cyc(1, l, r, j, p, 0, 1, ex, ey, es, nm);
   endtask

   // Monitor: outputs registered at a flagged edge are compared at the following falling edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge vga_clk);
         take = chk;
         @(negedge vga_clk);
         if (take) begin
            n_total++;
            if (sb.size() == 0) begin
               $display("FAIL sb_empty: monitor saw a checked cycle with no expectation queued");
            end else begin
               e = sb.pop_front();
               if (AkumaX === e.x && AkumaY === e.y && sprite === e.spr && attack_active === e.atk)
                  n_pass++;
               else
                  $display("FAIL %s: got X=%0d Y=%0d sprite=%0d atk=%0d, expected X=%0d Y=%0d sprite=%0d atk=%0d",
                           e.nm, AkumaX, AkumaY, sprite, attack_active, e.x, e.y, e.spr, e.atk);
            end
         end
      end
   end

   initial begin
      repeat (2) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "");
      cyc(0, 0, 0, 0, 0, 1, 1, 100, 300, 0, "reset_state");

      // Full jump from rest.
      tick(0, 0, 1, 0, 100, jy[0], 2, "jump_t1");
      for (int k = 2; k <= 25; k++)
         tick(0, 0, 0, 0, 100, jy[k-1], (k == 25) ? 0 : 2, "jump_arc");

      // Held punch triggers exactly once.
      for (int k = 1; k <= 30; k++)
         tick(0, 0, 0, 1, 100, 300, (k <= 12) ? 1 : 0, "punch_hold");
      tick(0, 0, 0, 0, 100, 300, 0, "punch_release");

      // Walk to the left clamp.
      for (int k = 1; k <= 48; k++)
         tick(1, 0, 0, 0, 100 - 2*k, 300, 0, "walk_left");
      for (int k = 0; k < 5; k++)
         tick(1, 0, 0, 0, lx[k], 300, 0, "clamp_left");

      // Walk to the right clamp.
      for (int k = 1; k <= 279; k++)
         tick(0, 1, 0, 0, 2*k, 300, 0, "walk_right");
      for (int k = 0; k < 3; k++)
         tick(0, 1, 0, 0, 560, 300, 0, "clamp_right");
      tick(1, 1, 0, 0, 560, 300, 0, "both_lr");

      // Jump and punch rise together; punch held through the jump and landing, drifting left.
      tick(0, 0, 1, 1, 560, jy[0], 2, "jump_beats_punch");
      for (int k = 2; k <= 25; k++)
         tick(1, 0, 0, 1, 560 - 2*(k-1), jy[k-1], (k == 25) ? 0 : 2, "air_drift");
      tick(0, 0, 0, 1, 512, 300, 0, "held_punch_landed");
      tick(0, 0, 0, 0, 512, 300, 0, "release_after_land");

      // Reset during jump tick 7, asserted together with frame_tick.
      tick(0, 0, 1, 0, 512, jy[0], 2, "jump2_t1");
      for (int k = 2; k <= 7; k++)
         tick(0, 0, 0, 0, 512, jy[k-1], 2, "jump2_arc");
      cyc(1, 0, 0, 0, 0, 1, 1, 100, 300, 0, "reset_midjump");

      // No tick: buttons toggle, outputs hold.
      for (int k = 0; k < 16; k++)
         cyc(0, k & 1, (k >> 1) & 1, (k >> 2) & 1, (k >> 3) & 1, 0, 1, 100, 300, 0, "idle_hold");

      // Punch spanning idle cycles; no walking while punching.
      tick(0, 0, 0, 1, 100, 300, 1, "punch_entry");
      for (int k = 0; k < 4; k++)
         cyc(0, 1, k & 1, 1, (k >> 1) & 1, 0, 1, 100, 300, 1, "idle_in_punch");
      for (int k = 1; k <= 12; k++)
         tick(1, 0, 0, 0, 100, 300, (k < 12) ? 1 : 0, "punch_nomove");
      tick(1, 0, 0, 0, 98, 300, 0, "walk_after_punch");

      // Reset mid-punch.
      tick(0, 0, 0, 1, 98, 300, 1, "punch2_entry");
      tick(0, 0, 0, 0, 98, 300, 1, "punch2_t2");
      cyc(0, 0, 0, 0, 0, 1, 1, 100, 300, 0, "reset_midpunch");

      // Punch edge on jump tick 20.
      tick(0, 0, 1, 0, 100, jy[0], 2, "jump3_t1");
      for (int k = 2; k <= 19; k++)
         tick(0, 0, 0, 0, 100, jy[k-1], 2, "jump3_arc");
      for (int k = 20; k <= 25; k++)
         tick(0, 0, 0, 1, 100, jy[k-1], (k == 25) ? 0 : AIR_SPR, "air_punch");
      tick(0, 0, 0, 0, 100, 300, 0, "after_air_punch");

      repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
      n_total++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL sb_drain: got %0d entries left, expected 0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
